pipe_stage_chain: RTL and testbench

- Parametrised successor to the fixed per-stage pipeline buffers between F/D, D/E, E/M and M/W.
- One instance implements an N-stage chain of payload registers, each with a valid bit.
- Each stage has stall (hold) and flush (kill) control. A stall propagates upstream automatically, and a bubble is inserted downstream of a held stage.
- Saturating performance counters track stall cycles, flush events and retired entries, for pipeline bring-up and hazard-unit verification.

---
 rtl/pipe_stage_chain.sv | 107 ++++++++++
 tb/tb_pipe_stage_chain.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// N-stage payload register chain with per-stage stall/flush, upstream stall
// propagation, downstream bubble insertion and saturating performance counters.
module pipe_stage_chain #(
    parameter int W      = 16,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    input  logic                  clr_cnt,
    output logic [STAGES-1:0]     stage_valid,
    output logic [STAGES*W-1:0]   stage_data,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0]   valid_q;
    logic [STAGES*W-1:0] data_q;
    logic [STAGES-1:0]   hold;
    logic [STAGES-1:0]   adv_valid;
    logic [STAGES*W-1:0] adv_data;
    logic [STAGES-1:0]   load_valid;
    logic [STAGES*W-1:0] load_data;
    logic [STAGES-1:0]   next_valid;
    logic [STAGES*W-1:0] next_data;
    logic                any_stall;
    logic                kill_event;
    logic                retire_event;

    // A stall anywhere downstream freezes this stage as well.
    always_comb begin
        hold = '0;
        for (int i = 0; i < STAGES; i++) begin
            hold[i] = |(stall >> i);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign adv_valid[0]   = in_valid;
            assign adv_data[0 +: W] = in_valid ? in_data : '0;
        end else begin : g_body
            // A held predecessor hands over a bubble rather than a copy of itself.
            assign adv_valid[g]       = valid_q[g-1] & ~hold[g-1];
            assign adv_data[g*W +: W] = hold[g-1] ? '0 : data_q[(g-1)*W +: W];
        end

        assign load_valid[g]       = hold[g] ? valid_q[g] : adv_valid[g];
        assign load_data[g*W +: W] = hold[g] ? data_q[g*W +: W] : adv_data[g*W +: W];
        assign next_valid[g]       = load_valid[g] & ~flush[g];
        assign next_data[g*W +: W] = flush[g] ? '0 : load_data[g*W +: W];
    end

    assign any_stall    = |stall;
    assign kill_event   = |(flush & load_valid);
    assign retire_event = valid_q[STAGES-1] & ~stall[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= next_valid;
            data_q  <= next_data;
        end
    end

    // Counters stick at their maximum instead of wrapping; clearing wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (any_stall && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (kill_event && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (retire_event && retire_cnt != CNT_MAX) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    assign in_ready    = ~hold[0];
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[(STAGES-1)*W +: W];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a queue-level model.
module tb_pipe_stage_chain;

    localparam int W    = 8;
    localparam int S    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_ready;
    logic [S-1:0]    stall;
    logic [S-1:0]    flush;
    logic            clr_cnt;
    logic [S-1:0]    stage_valid;
    logic [S*W-1:0]  stage_data;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   stall_cnt;
    logic [CW-1:0]   flush_cnt;
    logic [CW-1:0]   retire_cnt;

    int total;
    int bad;

    logic         m_v [S];
    logic [W-1:0] m_d [S];
    int           m_stall;
    int           m_flush;
    int           m_retire;
    bit           m_captured;

    pipe_stage_chain #(.W(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .clr_cnt    (clr_cnt),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .retire_cnt (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEqual(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < S; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_stall    = 0;
        m_flush    = 0;
        m_retire   = 0;
        m_captured = 1'b1;
    endtask

    // Everything at or below the highest stalled stage freezes, the stage just
    // above it takes a bubble, the rest shift up; flushes then wipe their stage.
    task automatic modelStep();
        logic         nv [S];
        logic [W-1:0] nd [S];
        int  top;
        bit  killed;
        bit  retired;
        top     = -1;
        killed  = 1'b0;
        retired = m_v[S-1] && !stall[S-1];
        for (int i = 0; i < S; i++) if (stall[i]) top = i;
        for (int i = 0; i < S; i++) begin
            if (i <= top) begin
                nv[i] = m_v[i];
                nd[i] = m_d[i];
            end else if (i == 0) begin
                nv[i] = in_valid;
                nd[i] = in_valid ? in_data : '0;
            end else if (i == top + 1) begin
                nv[i] = 1'b0;
                nd[i] = '0;
            end else begin
                nv[i] = m_v[i-1];
                nd[i] = m_d[i-1];
            end
            if (flush[i]) begin
                if (nv[i]) killed = 1'b1;
                nv[i] = 1'b0;
                nd[i] = '0;
            end
        end
        for (int i = 0; i < S; i++) begin
            m_v[i] = nv[i];
            m_d[i] = nd[i];
        end
        if (clr_cnt) begin
            m_stall  = 0;
            m_flush  = 0;
            m_retire = 0;
        end else begin
            if (stall != '0 && m_stall < CMAX) m_stall++;
            if (killed && m_flush < CMAX) m_flush++;
            if (retired && m_retire < CMAX) m_retire++;
        end
        m_captured = (stall == '0);
    endtask

    task automatic checkOutput();
        logic [S-1:0]   ev;
        logic [S*W-1:0] ed;
        for (int i = 0; i < S; i++) begin
            ev[i]        = m_v[i];
            ed[i*W +: W] = m_d[i];
        end
        checkEqual("stage_valid", 64'(stage_valid), 64'(ev));
        checkEqual("stage_data", 64'(stage_data), 64'(ed));
        checkEqual("out_valid", 64'(out_valid), 64'(m_v[S-1]));
        checkEqual("out_data", 64'(out_data), 64'(m_d[S-1]));
        checkEqual("in_ready", 64'(in_ready), 64'(stall == '0));
        checkEqual("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        checkEqual("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        checkEqual("retire_cnt", 64'(retire_cnt), 64'(m_retire));
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [S-1:0] st,
                                 input logic [S-1:0] fl, input logic clr);
        in_valid = v;
        in_data  = d;
        stall    = st;
        flush    = fl;
        clr_cnt  = clr;
    endtask

    task automatic runCycle(input logic v, input logic [W-1:0] d, input logic [S-1:0] st,
                            input logic [S-1:0] fl, input logic clr);
        applyStimulus(v, d, st, fl, clr);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Input is only allowed to change once the previous offer was taken.
    task automatic randomCycle();
        logic         v;
        logic [W-1:0] d;
        logic [S-1:0] st;
        logic [S-1:0] fl;
        v = in_valid;
        d = in_data;
        if (m_captured) begin
            v = ($urandom_range(0, 9) < 7);
            d = W'($urandom);
        end
        for (int i = 0; i < S; i++) begin
            st[i] = ($urandom_range(0, 7) == 0);
            fl[i] = ($urandom_range(0, 9) == 0);
        end
        runCycle(v, d, st, fl, ($urandom_range(0, 29) == 0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        modelReset();
        #12;
        checkEqual("reset_valid", 64'(stage_valid), 64'h0);
        checkEqual("reset_data", 64'(stage_data), 64'h0);
        checkEqual("reset_stall_cnt", 64'(stall_cnt), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        runCycle(1'b1, 8'h11, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'h22, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'h33, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        checkEqual("lat_out0", 64'({out_valid, out_data}), 64'h111);
        runCycle(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        checkEqual("lat_out1", 64'({out_valid, out_data}), 64'h122);
        runCycle(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        checkEqual("lat_out2", 64'({out_valid, out_data}), 64'h133);
        runCycle(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        checkEqual("retire_three", 64'(retire_cnt), 64'd3);

        runCycle(1'b1, 8'hD4, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'hC3, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'hB2, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'hA1, 4'b0000, 4'b0000, 1'b0);
        checkEqual("full_chain", 64'(stage_data), 64'hD4C3B2A1);
        applyStimulus(1'b1, 8'hE5, 4'b0010, 4'b0000, 1'b0);
        #1;
        checkEqual("stall_in_ready", 64'(in_ready), 64'h0);
        runCycle(1'b1, 8'hE5, 4'b0010, 4'b0000, 1'b0);
        runCycle(1'b1, 8'hE5, 4'b0010, 4'b0000, 1'b0);
        checkEqual("stall_valid", 64'(stage_valid), 64'b0011);
        checkEqual("stall_data", 64'(stage_data), 64'h0000B2A1);
        checkEqual("stall_cnt_two", 64'(stall_cnt), 64'd2);
        checkEqual("retire_drain", 64'(retire_cnt), 64'd5);
        runCycle(1'b1, 8'hE5, 4'b0000, 4'b0000, 1'b0);

        runCycle(1'b1, 8'hF6, 4'b0000, 4'b0011, 1'b0);
        checkEqual("flush_valid", 64'(stage_valid), 64'b1100);
        checkEqual("flush_data", 64'(stage_data), 64'hB2A10000);
        checkEqual("flush_cnt_one", 64'(flush_cnt), 64'd1);

        runCycle(1'b1, 8'h17, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'h28, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'h39, 4'b0000, 4'b0000, 1'b0);
        runCycle(1'b1, 8'h4A, 4'b0100, 4'b0100, 1'b0);
        checkEqual("fs_valid", 64'(stage_valid), 64'b0011);
        checkEqual("fs_data", 64'(stage_data), 64'h00002839);
        checkEqual("fs_flush_cnt", 64'(flush_cnt), 64'd2);
        runCycle(1'b1, 8'h4A, 4'b0000, 4'b0000, 1'b0);

        for (int k = 0; k < 20; k++) runCycle(1'b1, 8'h4A, 4'b0001, 4'b0000, 1'b0);
        checkEqual("stall_sat", 64'(stall_cnt), 64'd15);
        runCycle(1'b1, 8'h4A, 4'b0000, 4'b0000, 1'b1);
        checkEqual("clr_counts", 64'({stall_cnt, flush_cnt, retire_cnt}), 64'h0);

        for (int k = 0; k < 400; k++) randomCycle();

        #2;
        rst = 1'b1;
        #1;
        checkEqual("async_valid", 64'(stage_valid), 64'h0);
        checkEqual("async_data", 64'(stage_data), 64'h0);
        checkEqual("async_counts", 64'({stall_cnt, flush_cnt, retire_cnt}), 64'h0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 300; k++) randomCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
